seq_mult_shift_add: RTL
=======================

// Module: seq_mult_shift_add
// PURPOSE
//  Parametrised sequential shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit per clock.
//  Successor to the fixed 16-bit shift/accumulate multiplier. Adds valid/ready start handshake, per-op signed/unsigned mode,
//  a single-cycle done pulse, mid-operation abort and optional early termination.
//  Sits beside datapath blocks that need a low-area multiplier and can tolerate multi-cycle latency.
// PARAMETERS
//  WIDTH      16  operand width in bits; legal range 2..32
//  EARLY_EXIT 0   1: finish as soon as all remaining multiplier bits are zero
// PORTS
//  clk           in   1        single clock; all state on rising edge
//  rst           in   1        asynchronous reset, active-high
//  start_valid   in   1        request: operands valid this cycle
//  start_ready   out  1        block can accept (1 only in IDLE)
//  signed_mode   in   1        sampled on accept; 1 = two's-complement operands
//  ain           in   WIDTH    multiplicand, sampled on accept
//  bin           in   WIDTH    multiplier, sampled on accept
//  abort         in   1        cancel the operation in progress
//  busy          out  1        1 in RUN or DONE
//  done          out  1        1-cycle pulse: yout holds the new product
//  yout          out  2*WIDTH  product register; held until the next done
// BEHAVIOUR
//  Reset: state=IDLE, yout=0, done=0, busy=0, start_ready=1; all internal registers cleared.
//  Reset mid-operation discards the operation. No done pulse follows reset.
//  Accept = start_valid & start_ready at a rising edge.
//   On accept, latch areg=|ain|, breg=|bin|, neg=signed_mode&(ain[MSB]^bin[MSB]), acc=0, cnt=0; state->RUN.
//   In unsigned mode, |x| = x.
//  RUN, each edge:
//   if breg[0], acc += areg << cnt (2W-bit add, no overflow possible)
//   then breg >>= 1; cnt++
//  RUN -> DONE when cnt==WIDTH-1 has just been processed, or when EARLY_EXIT=1 and the shifted breg==0.
//  The same edge loads yout = neg ? -acc_final : acc_final and sets done=1.
//  DONE lasts exactly 1 cycle (done=1, busy=1, start_ready=0), then returns to IDLE with done=0.
//  Latency (EARLY_EXIT=0): accept at edge E0 -> done high in the cycle after edge E(WIDTH).
//   Next accept is possible at E(WIDTH+2) at the earliest.
//  Latency (EARLY_EXIT=1): done rises in the cycle after edge E(k), k = max(1, index of highest set bit of |bin| + 1).
//   bin==0 completes after 1 RUN cycle.
//  Abort: sampled in RUN only. Next edge -> IDLE; yout unchanged; no done pulse. Ignored in IDLE and DONE.
//   Abort on the same edge that would enter DONE: abort wins.
//  start_valid while not ready: ignored, no queuing. Operand inputs may change freely after accept.
//  Signed corner: ain=bin=-2^(W-1) gives magnitudes 2^(W-1) (W-bit unsigned) and product +2^(2W-2); this fits, no saturation.
//  Mixed signs producing zero: yout=0 (negating 0 yields 0).
//  yout is registered; done and busy are registered or decoded from registered state; no combinational path from inputs to outputs.
//   Exception: start_ready is state-decoded only.
// STRUCTURE
//  mult_pkg: state enum {IDLE, RUN, DONE} (2-bit); function cnt_w(WIDTH)=$clog2(WIDTH); helper function abs_w.
//  One natural sub-module: seq_mult_sign_unit.
//   Combinational magnitude on load; conditional 2W-bit negate on finish.
//   Shared by both operands, each via its own instance.
//  Top level holds the FSM, counter, shift registers and accumulator.
//  No other hierarchy.
// TESTING
//  1 Unsigned, W=16: ain=0x00FF, bin=0x0100 -> done in cycle after E16, yout=0x0000FF00, one-cycle pulse.
//  2 Signed: ain=-3 (0xFFFD), bin=7 -> yout=0xFFFFFFEB (-21).
//    Signed: ain=bin=0x8000 -> yout=0x40000000.
//  3 Unsigned max: ain=bin=0xFFFF -> yout=0xFFFE0001.
//    Same operands with signed_mode=1 -> yout=0x00000001.
//  4 Abort asserted at RUN cycle 5 -> no done; yout keeps the previous product; start_ready=1 the next cycle; new op completes correctly.
//  5 EARLY_EXIT=1: bin=0x0003 -> done after 2 RUN edges; bin=0 -> after 1 edge with yout=0.
//    EARLY_EXIT=0 with bin=0x0003 -> done after 16 edges.
//  6 rst pulsed mid-RUN -> yout=0, done=0, start_ready=1 immediately.
//    start_valid held high through a full op -> back-to-back ops spaced WIDTH+2 cycles.
//    Random signed/unsigned products compared against a reference model.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count multiplier positions 0..width-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Two's-complement negate when neg is set; callers truncate to their own width.
  function automatic logic [63:0] abs_w(input logic [63:0] x, input logic neg);
    return neg ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/seq_mult_sign_unit.sv
// Conditional two's-complement negate of a W-bit value: magnitude of a signed operand
// on load, or sign restoration of the 2W-bit product on finish.
module seq_mult_sign_unit
  import mult_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = W'(abs_w(64'(x), neg));

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier: one multiplier bit per clock,
// valid/ready start, signed/unsigned per op, abort, optional early exit.
module seq_mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     ain,
  input  logic [WIDTH-1:0]     bin,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   yout
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] breg_next;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    product;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  seq_mult_sign_unit #(.W(WIDTH)) u_sign_a (
    .x   (ain),
    .neg (signed_mode & ain[WIDTH-1]),
    .y   (mag_a)
  );

  seq_mult_sign_unit #(.W(WIDTH)) u_sign_b (
    .x   (bin),
    .neg (signed_mode & bin[WIDTH-1]),
    .y   (mag_b)
  );

  // Product sign is applied to the final accumulator value in the finishing cycle.
  seq_mult_sign_unit #(.W(PW)) u_sign_p (
    .x   (acc_next),
    .neg (neg),
    .y   (product)
  );

  always_comb begin
    addend    = breg[0] ? (PW'(areg) << cnt) : '0;
    acc_next  = acc + addend;
    breg_next = breg >> 1;
    last_bit  = (cnt == CW'(WIDTH - 1)) ||
                ((EARLY_EXIT != 0) && (breg_next == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      areg  <= '0;
      breg  <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      yout  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            areg  <= mag_a;
            breg  <= mag_b;
            neg   <= signed_mode & (ain[WIDTH-1] ^ bin[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Abort beats completion when both land on the same edge.
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            acc  <= acc_next;
            breg <= breg_next;
            cnt  <= cnt + CW'(1);
            if (last_bit) begin
              yout  <= product;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign start_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

endmodule
